// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button debounce/pulse stage.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEATING,
        RELEASE_WAIT
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY  = 20;
    localparam int DEF_REPEAT_PERIOD = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_pulser_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/btn_debounce_pulser.sv
// Synchronizes and debounces a raw button, emitting one count strobe per
// accepted press plus optional auto-repeat strobes while the button is held.
module btn_debounce_pulser
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic pulse,
    output logic btn_level,
    output logic held
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    // stab_cnt == *_LAST means the current sample is the STABLE_CYCLES-th one
    localparam logic [SW-1:0] STAB_LAST   = SW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          btn_s;
    state_t        state_q, state_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          pulse_q, pulse_d;
    logic          level_q, level_d;
    logic          held_q, held_d;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_in),
        .q_o   (btn_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stab_q  <= '0;
            rpt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            rpt_q   <= rpt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stab_d  = '0;
        rpt_d   = rpt_q;
        case (state_q)
            IDLE: begin
                rpt_d = '0;
                if (btn_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = PRESSED;
                    end else begin
                        state_d = PRESS_WAIT;
                        stab_d  = SW'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                rpt_d = '0;
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (stab_q == STAB_LAST) begin
                    state_d = PRESSED;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            PRESSED, REPEATING: begin
                if (!btn_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = IDLE;
                        rpt_d   = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        stab_d  = SW'(1);
                    end
                end else if (repeat_en) begin
                    if (rpt_q == ((state_q == PRESSED) ? DELAY_LAST : PERIOD_LAST)) begin
                        state_d = REPEATING;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high resumes where we left off, without a new press strobe
                if (btn_s) begin
                    state_d = held_q ? REPEATING : PRESSED;
                end else if (stab_q == STAB_LAST) begin
                    state_d = IDLE;
                    rpt_d   = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rpt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pulse_d = ((state_q == IDLE || state_q == PRESS_WAIT) && state_d == PRESSED)
               || (state_q == PRESSED && state_d == REPEATING)
               || (state_q == REPEATING && btn_s && repeat_en && rpt_q == PERIOD_LAST);
        level_d = (state_d == PRESSED) || (state_d == REPEATING) || (state_d == RELEASE_WAIT);
        held_d  = (state_d == REPEATING) || (state_d == RELEASE_WAIT && held_q);
    end

    assign pulse     = pulse_q;
    assign btn_level = level_q;
    assign held      = held_q;

endmodule

// File: tb/tb_btn_debounce_pulser.sv
// Directed bench for btn_debounce_pulser with a window-based behavioural model.
module tb_btn_debounce_pulser;

    localparam int S   = 4;
    localparam int D   = 20;
    localparam int PER = 8;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic repeat_en;
    logic pulse;
    logic btn_level;
    logic held;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pq[$];
    logic [7:0] ctr8 = 8'd0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    btn_debounce_pulser #(
        .STABLE_CYCLES (S),
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (PER)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .repeat_en (repeat_en),
        .pulse     (pulse),
        .btn_level (btn_level),
        .held      (held)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pulse_at(input int i);
        if (i < pq.size()) return pq[i];
        return -1000;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: level flips when the last S synchronized samples all disagree with it;
    // repeat strobes come from counting enabled, uninterrupted held cycles.
    logic [1:0]   m_sync;
    logic [S-2:0] m_hist;
    logic         m_level, m_prev, m_pulse, m_held;
    int           m_cnt;

    always @(posedge clk) begin : model_p
        logic bs, all_diff, nl, counted;
        int cn;
        if (reset) begin
            m_sync  <= '0;
            m_hist  <= '0;
            m_level <= 1'b0;
            m_prev  <= 1'b0;
            m_pulse <= 1'b0;
            m_held  <= 1'b0;
            m_cnt   <= 0;
        end else begin
            bs = m_sync[1];
            all_diff = (bs != m_level);
            for (int i = 0; i < S - 1; i++)
                if (m_hist[i] == m_level) all_diff = 1'b0;
            nl = all_diff ? ~m_level : m_level;
            counted = m_level && nl && bs && m_prev && repeat_en;
            cn = nl ? (m_cnt + (counted ? 1 : 0)) : 0;
            m_pulse <= (!m_level && nl) ||
                       (counted && (cn == D || (cn > D && ((cn - D) % PER) == 0)));
            m_held  <= nl && (cn >= D);
            m_level <= nl;
            m_cnt   <= cn;
            m_prev  <= bs;
            m_hist  <= {m_hist[S-3:0], bs};
            m_sync  <= {m_sync[0], btn_in};
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_pulse", int'(pulse), int'(m_pulse));
            chk("model_btn_level", int'(btn_level), int'(m_level));
            chk("model_held", int'(held), int'(m_held));
            if (pulse) begin
                pq.push_back(cyc);
                ctr8 <= ctr8 + 8'd1;
            end
        end
    end

    initial begin : stim
        int t0, tr, p0;
        int exp_off[6];
        exp_off = '{0, 20, 28, 36, 44, 52};
        reset = 1'b1;
        btn_in = 1'b0;
        repeat_en = 1'b0;
        step(1);
        started = 1'b1;
        step(1);
        chk("reset_pulse", int'(pulse), 0);
        chk("reset_btn_level", int'(btn_level), 0);
        chk("reset_held", int'(held), 0);
        reset = 1'b0;
        step(3);

        // clean press, no repeat
        pq.delete();
        t0 = cyc;
        btn_in = 1'b1;
        step(10);
        chk("press_pulse_count", pq.size(), 1);
        chk("press_latency", pulse_at(0) - t0, 6);
        chk("press_btn_level", int'(btn_level), 1);
        chk("counter_0_to_1", int'(ctr8), 1);
        btn_in = 1'b0;
        step(8);
        chk("release_btn_level", int'(btn_level), 0);
        chk("release_no_pulse", pq.size(), 1);

        // bounce on press
        pq.delete();
        btn_in = 1'b1;
        step(3);
        btn_in = 1'b0;
        step(1);
        tr = cyc;
        btn_in = 1'b1;
        step(12);
        chk("bounce_pulse_count", pq.size(), 1);
        chk("bounce_latency", pulse_at(0) - tr, 6);
        btn_in = 1'b0;
        step(8);

        // auto-repeat
        pq.delete();
        repeat_en = 1'b1;
        t0 = cyc;
        btn_in = 1'b1;
        step(6);
        p0 = t0 + 6;
        chk("repeat_held_at_press", int'(held), 0);
        for (int i = 1; i <= 59; i++) begin
            step(1);
            if (i == 19) chk("repeat_held_before_20", int'(held), 0);
            if (i == 20) chk("repeat_held_at_20", int'(held), 1);
        end
        chk("repeat_pulse_count", pq.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("repeat_offset_%0d", i), pulse_at(i) - p0, exp_off[i]);

        // release glitch while repeating: count freezes for 3 edges
        pq.delete();
        btn_in = 1'b0;
        step(2);
        btn_in = 1'b1;
        step(14);
        chk("glitch_pulse_count", pq.size(), 2);
        chk("glitch_pulse0", pulse_at(0) - p0, 60);
        chk("glitch_pulse1", pulse_at(1) - p0, 71);
        chk("glitch_btn_level", int'(btn_level), 1);
        chk("glitch_held", int'(held), 1);

        // real release
        pq.delete();
        btn_in = 1'b0;
        step(5);
        chk("release_not_early", int'(btn_level), 1);
        step(1);
        chk("release_rpt_btn_level", int'(btn_level), 0);
        chk("release_rpt_held", int'(held), 0);
        chk("release_rpt_no_pulse", pq.size(), 0);
        repeat_en = 1'b0;
        step(4);

        // reset while debouncing a press
        pq.delete();
        btn_in = 1'b1;
        step(5);
        reset = 1'b1;
        step(1);
        chk("midreset_pulse", int'(pulse), 0);
        chk("midreset_btn_level", int'(btn_level), 0);
        chk("midreset_held", int'(held), 0);
        reset = 1'b0;
        tr = cyc;
        step(10);
        chk("midreset_pulse_count", pq.size(), 1);
        chk("midreset_latency", pulse_at(0) - tr, 6);
        btn_in = 1'b0;
        step(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
